// File: rtl/decode_pipe.sv
// decode_pipe: registered, flow-controlled MIPS decode stage with load-use bubbles
module decode_pipe #(
  parameter int W_CPU = 32,
  parameter int W_REG = 5,
  parameter int LOAD_STALL = 1,
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_CPU-1:0] inst,
  input  logic [W_CPU-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_CPU-1:0] out_pc,
  output logic [W_REG-1:0] wa,
  output logic [W_REG-1:0] ra1,
  output logic [W_REG-1:0] ra2,
  output logic             reg_wen,
  output logic             imm_ext,
  output logic [15:0]      imm,
  output logic [25:0]      addr,
  output logic [5:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [1:0]       mem_cmd,
  output logic [1:0]       alu_src,
  output logic             reg_src,
  output logic             link,
  output logic             illegal,
  output logic [W_CNT-1:0] bubble_cnt
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07, F_SYSCALL = 6'h0C, F_BREAK = 6'h0D, F_ADD = 6'h20, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic WREN = 1'b1, WDIS = 1'b0, IMM_SIGN_EXT = 1'b1, IMM_ZERO_EXT = 1'b0;
  localparam logic REG_SRC_ALU = 1'b0, REG_SRC_MEM = 1'b1;
  localparam logic [1:0] PC_SRC_NEXT = 2'd0, PC_SRC_JUMP = 2'd1, PC_SRC_BRCH = 2'd2;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
  localparam logic [1:0] ALU_SRC_REG = 2'd0, ALU_SRC_IMM = 2'd1, ALU_SRC_SHA = 2'd2;
  localparam logic [W_REG-1:0] REG_0 = '0, REG_V0 = W_REG'(2), REG_A0 = W_REG'(4), REG_RA = W_REG'(31);
  typedef struct packed {
    logic [W_REG-1:0] wa, ra1, ra2;
    logic             reg_wen, imm_ext;
    logic [5:0]       alu_op;
    logic [1:0]       pc_src, mem_cmd, alu_src;
    logic             reg_src, link, illegal;
  } ctrl_t;
  localparam ctrl_t NOP = '{wa: REG_0, ra1: REG_0, ra2: REG_0, reg_wen: WDIS, imm_ext: IMM_ZERO_EXT,
                            alu_op: F_BREAK, pc_src: PC_SRC_NEXT, mem_cmd: MEM_NOP, alu_src: ALU_SRC_REG,
                            reg_src: REG_SRC_ALU, link: 1'b0, illegal: 1'b0};
  logic [5:0] op, fn;
  logic [W_REG-1:0] rs, rt, rd, pend_wa;
  logic [1:0] pend_cnt;
  logic adv, hazard, accept, lw_acc;
  ctrl_t dec, q;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  always_comb begin
    dec = NOP;
    case (op)
      OP_R:
        case (fn)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec.wa = rd; dec.ra1 = rs; dec.ra2 = rt; dec.reg_wen = WREN; dec.alu_op = fn;
          end
          F_SLL, F_SRL, F_SRA: begin
            dec.wa = rd; dec.ra1 = rt; dec.reg_wen = WREN; dec.alu_op = fn; dec.alu_src = ALU_SRC_SHA;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            dec.wa = rd; dec.ra1 = rt; dec.ra2 = rs; dec.reg_wen = WREN; dec.alu_op = fn;
          end
          F_SYSCALL: begin
            dec.ra1 = REG_V0; dec.ra2 = REG_A0;
          end
          F_BREAK: ;
          default: dec.illegal = 1'b1;
        endcase
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        // opcode bit 2 splits sign-extended arithmetic/compare from zero-extended logic ops
        dec.wa = rt; dec.ra1 = rs; dec.reg_wen = WREN; dec.alu_src = ALU_SRC_IMM;
        dec.imm_ext = op[2] ? IMM_ZERO_EXT : IMM_SIGN_EXT;
        dec.alu_op = op[2] ? {4'b1001, op[1:0]} : op[1] ? {5'b10101, op[0]} : {5'b10000, op[0]};
      end
      OP_LW: begin
        dec.wa = rt; dec.ra1 = rs; dec.reg_wen = WREN; dec.mem_cmd = MEM_READ; dec.reg_src = REG_SRC_MEM;
        dec.imm_ext = IMM_SIGN_EXT; dec.alu_op = F_ADDU; dec.alu_src = ALU_SRC_IMM;
      end
      OP_SW: begin
        dec.ra1 = rs; dec.ra2 = rt; dec.mem_cmd = MEM_WRITE;
        dec.imm_ext = IMM_SIGN_EXT; dec.alu_op = F_ADDU; dec.alu_src = ALU_SRC_IMM;
      end
      OP_BEQ, OP_BNE: begin
        dec.ra1 = rs; dec.ra2 = rt; dec.alu_op = F_SUBU; dec.pc_src = PC_SRC_BRCH; dec.imm_ext = IMM_SIGN_EXT;
      end
      OP_J: dec.pc_src = PC_SRC_JUMP;
      OP_JAL: begin
        dec.pc_src = PC_SRC_JUMP; dec.wa = REG_RA; dec.reg_wen = WREN; dec.link = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end
  assign adv = !out_valid || out_ready;
  assign hazard = pend_cnt != 2'd0 && pend_wa != REG_0 && (dec.ra1 == pend_wa || dec.ra2 == pend_wa);
  assign in_ready = rst && adv && !hazard;
  assign accept = in_valid && in_ready;
  assign lw_acc = accept && op == OP_LW && dec.wa != REG_0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      q <= NOP;
      out_pc <= '0;
      imm <= '0;
      addr <= '0;
      pend_cnt <= 2'd0;
      pend_wa <= REG_0;
      bubble_cnt <= '0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        q <= dec;
        out_pc <= in_pc;
        imm <= inst[15:0];
        addr <= inst[25:0];
      end else if (in_valid) begin
        q <= NOP;
        bubble_cnt <= bubble_cnt + W_CNT'(!(&bubble_cnt));
      end
      pend_cnt <= lw_acc ? 2'(LOAD_STALL) : pend_cnt - 2'(pend_cnt != 2'd0);
      if (lw_acc) pend_wa <= dec.wa;
    end
  end
  assign {wa, ra1, ra2, reg_wen, imm_ext, alu_op, pc_src, mem_cmd, alu_src, reg_src, link, illegal} = q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed and random checks of decode_pipe against a spec-level model
module tb_decode_pipe;
  localparam int LOAD_STALL = 1;
  localparam logic [31:0] NOP_W = {15'd0, 1'b0, 1'b0, 6'h0D, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, in_pc, out_pc;
  logic [4:0] wa, ra1, ra2;
  logic reg_wen, imm_ext, reg_src, link, illegal;
  logic [15:0] imm;
  logic [25:0] addr;
  logic [5:0] alu_op;
  logic [1:0] pc_src, mem_cmd, alu_src;
  logic [15:0] bubble_cnt;
  int nvec = 0, nbad = 0;
  logic m_valid;
  logic [31:0] m_ctrl, m_pc;
  logic [41:0] m_ia;
  logic [15:0] m_bub;
  logic [4:0] lw_dst;
  int since;

  decode_pipe #(.W_CPU(32), .W_REG(5), .LOAD_STALL(LOAD_STALL), .W_CNT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .wa(wa), .ra1(ra1), .ra2(ra2),
    .reg_wen(reg_wen), .imm_ext(imm_ext), .imm(imm), .addr(addr), .alu_op(alu_op), .pc_src(pc_src),
    .mem_cmd(mem_cmd), .alu_src(alu_src), .reg_src(reg_src), .link(link), .illegal(illegal),
    .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control word as {wa,ra1,ra2,wen,sext,alu_op,pc_src,mem,alu_src,reg_src,link,illegal}
  function automatic logic [31:0] model_dec(input logic [31:0] i);
    logic [5:0] op, fn, aop;
    logic [4:0] rs, rt, rd, w, r1, r2;
    logic wen, sext, rsrc, lnk, ill;
    logic [1:0] pcs, mem, asrc;
    op = i[31:26]; fn = i[5:0]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11];
    w = 0; r1 = 0; r2 = 0; wen = 0; sext = 0; rsrc = 0; lnk = 0; ill = 0; pcs = 0; mem = 0; asrc = 0;
    aop = 6'h0D;
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}) begin
        w = rd; r1 = rs; r2 = rt; wen = 1; aop = fn;
      end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
        w = rd; r1 = rt; wen = 1; aop = fn; asrc = 2;
      end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
        w = rd; r1 = rt; r2 = rs; wen = 1; aop = fn;
      end else if (fn == 6'h0C) begin
        r1 = 5'd2; r2 = 5'd4;
      end else if (fn != 6'h0D) ill = 1;
    end else if (op >= 6'h08 && op <= 6'h0E) begin
      w = rt; r1 = rs; wen = 1; asrc = 1; sext = op < 6'h0C;
      case (op)
        6'h08: aop = 6'h20;
        6'h09: aop = 6'h21;
        6'h0A: aop = 6'h2A;
        6'h0B: aop = 6'h2B;
        6'h0C: aop = 6'h24;
        6'h0D: aop = 6'h25;
        default: aop = 6'h26;
      endcase
    end else if (op == 6'h23) begin
      w = rt; r1 = rs; wen = 1; mem = 1; rsrc = 1; sext = 1; aop = 6'h21; asrc = 1;
    end else if (op == 6'h2B) begin
      r1 = rs; r2 = rt; mem = 2; sext = 1; aop = 6'h21; asrc = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      r1 = rs; r2 = rt; aop = 6'h23; pcs = 2; sext = 1;
    end else if (op == 6'h02) pcs = 1;
    else if (op == 6'h03) begin
      pcs = 1; w = 5'd31; wen = 1; lnk = 1;
    end else ill = 1;
    return {w, r1, r2, wen, sext, aop, pcs, mem, asrc, rsrc, lnk, ill};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = NOP_W; m_pc = 0; m_ia = 0; m_bub = 0; lw_dst = 0; since = 100;
  endtask

  // One clock: drive, check at the falling edge, then advance the model at the rising edge
  task automatic cycle(input logic r, input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic ordy);
    logic [31:0] d;
    logic hz, ad, acc;
    rst = r; in_valid = v; inst = i; in_pc = p; out_ready = ordy;
    @(negedge clk);
    d = model_dec(i);
    hz = lw_dst != 0 && since < LOAD_STALL && (d[26:22] == lw_dst || d[21:17] == lw_dst);
    ad = !m_valid || ordy;
    chk("in_ready", 64'(in_ready), 64'(r && ad && !hz));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("ctrl", 64'({wa, ra1, ra2, reg_wen, imm_ext, alu_op, pc_src, mem_cmd, alu_src, reg_src, link, illegal}),
        64'(m_ctrl));
    chk("out_pc", 64'(out_pc), 64'(m_pc));
    chk("imm_addr", 64'({imm, addr}), 64'(m_ia));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    @(posedge clk);
    if (!r) model_reset();
    else if (ad) begin
      acc = v && !hz;
      if (acc && i[31:26] == 6'h23 && i[20:16] != 0) begin
        lw_dst = i[20:16]; since = 0;
      end else if (since < 8) since++;
      m_valid = acc;
      if (acc) begin
        m_ctrl = d; m_pc = p; m_ia = {i[15:0], i[25:0]};
      end else if (v) begin
        m_ctrl = NOP_W;
        if (m_bub != 16'hFFFF) m_bub++;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] ops[12];
    logic [5:0] fns[8];
    logic [5:0] op;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C, 6'h23, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h00, 6'h04, 6'h0C, 6'h0D, 6'h20, 6'h22, 6'h2A, 6'h3F};
    if ($urandom_range(0, 15) == 0) return $urandom;
    op = ops[$urandom_range(0, 11)];
    return {op, 3'b0, 2'($urandom), 3'b0, 2'($urandom), 3'b0, 2'($urandom), 5'($urandom),
            op == 6'h00 ? fns[$urandom_range(0, 7)] : 6'($urandom)};
  endfunction

  initial begin
    rst = 0; in_valid = 0; inst = 0; in_pc = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_bubble", 64'(bubble_cnt), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_nop_aluop", 64'(alu_op), 64'(6'h0D));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    cycle(1, 0, 0, 0, 1);
    // back-to-back ALU ops
    cycle(1, 1, 32'h20080005, 32'h100, 1);
    chk("addi_wa", 64'(wa), 64'(8));
    chk("addi_op", 64'(alu_op), 64'(6'h20));
    chk("addi_src", 64'(alu_src), 64'(1));
    cycle(1, 1, 32'h01084820, 32'h104, 1);
    chk("add_wa", 64'(wa), 64'(9));
    chk("add_ra", 64'({ra1, ra2}), 64'({5'd8, 5'd8}));
    chk("add_valid", 64'(out_valid), 64'(1));
    cycle(1, 0, 0, 0, 1);
    // no false hazard: independent instruction in between, then load into $zero
    cycle(1, 1, 32'h8FA80000, 32'h200, 1);
    cycle(1, 1, 32'h200A0001, 32'h204, 1);
    cycle(1, 1, 32'h01084820, 32'h208, 1);
    chk("nofalse_pc", 64'(out_pc), 64'(32'h208));
    cycle(1, 1, 32'h8FA00000, 32'h20C, 1);
    cycle(1, 1, 32'h00004820, 32'h210, 1);
    chk("zero_dst_pc", 64'(out_pc), 64'(32'h210));
    chk("nofalse_bubble", 64'(bubble_cnt), 64'(0));
    // load-use stall
    cycle(1, 1, 32'h8FA80000, 32'h300, 1);
    cycle(1, 1, 32'h01084820, 32'h304, 1);
    chk("stall_valid", 64'(out_valid), 64'(0));
    chk("stall_bubble", 64'(bubble_cnt), 64'(1));
    cycle(1, 1, 32'h01084820, 32'h304, 1);
    chk("stall_issue", 64'({out_valid, wa}), 64'({1'b1, 5'd9}));
    // reset during a pending load
    cycle(1, 1, 32'h8FA80000, 32'h400, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 32'h01084820, 32'h404, 1);
    chk("rststall_issue", 64'({out_valid, out_pc}), 64'({1'b1, 32'h404}));
    chk("rststall_bubble", 64'(bubble_cnt), 64'(0));
    // backpressure
    cycle(1, 1, 32'h200A0001, 32'h500, 1);
    repeat (3) begin
      cycle(1, 1, 32'h01084820, 32'h504, 0);
      chk("bp_hold_pc", 64'(out_pc), 64'(32'h500));
    end
    cycle(1, 1, 32'h01084820, 32'h504, 1);
    chk("bp_release_pc", 64'(out_pc), 64'(32'h504));
    cycle(1, 0, 0, 0, 1);
    chk("bp_no_dup", 64'(out_valid), 64'(0));
    // special decodes
    cycle(1, 1, 32'h0C100000, 32'h600, 1);
    chk("jal", 64'({wa, link, pc_src}), 64'({5'd31, 1'b1, 2'd1}));
    cycle(1, 1, 32'hFC000000, 32'h604, 1);
    chk("illegal", 64'({illegal, reg_wen, mem_cmd}), 64'({1'b1, 1'b0, 2'd0}));
    cycle(1, 1, 32'hAFA80004, 32'h608, 1);
    chk("sw", 64'({reg_wen, ra2}), 64'({1'b0, 5'd8}));
    // random traffic
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0, rnd_inst(), $urandom,
            $urandom_range(0, 3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, flow-controlled MIPS instruction decode stage, the pipelined successor to the single-cycle combinational decoder. Accepts instruction/PC pairs over a valid/ready handshake, decodes them with the `lib/opcodes.v` encodings, and holds the control word in an output register for execute. Detects load-use hazards against recently issued `LW`s and inserts a parametrised number of bubbles. Also flags illegal encodings, marks `JAL` link writes, and keeps a saturating bubble counter.

## Interface
- `W_CPU`, 32, instruction and PC width.
- `W_REG`, 5, register address width.
- `LOAD_STALL`, 1, bubbles required between an `LW` and a dependent consumer; range 0–3; 0 disables hazard logic.
- `W_CNT`, 16, bubble counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `in_valid` in 1: `inst`/`in_pc` valid.
- `in_ready` out 1: stage accepts the input this cycle.
- `inst` in `W_CPU`: instruction word.
- `in_pc` in `W_CPU`: PC of `inst`.
- `out_valid` out 1: output register holds a decoded instruction.
- `out_ready` in 1: execute consumes the output this cycle.
- `out_pc` out `W_CPU`: registered PC.
- Decoded control word, all registered, with codebase widths: `wa`, `ra1`, `ra2`, `reg_wen`, `imm_ext`, `imm`, `addr`, `alu_op`, `pc_src`, `mem_cmd`, `alu_src`, `reg_src`.
- `link` out 1: the instruction writes the return address (`JAL`).
- `illegal` out 1: unrecognised opcode or funct.
- `bubble_cnt` out `W_CNT`: saturating count of inserted bubbles.

## Operation
- `adv = !out_valid || out_ready`. The output register loads only when `adv` is 1.
- `hazard = pend_cnt != 0 && pend_wa != 0 && (dec.ra1 == pend_wa || dec.ra2 == pend_wa)`.
- `in_ready = adv && !hazard`.
- **Accept** (`in_valid && in_ready`): output register <= decode(`inst`), `out_pc <= in_pc`, `out_valid <= 1`.
- **Bubble** (`adv && in_valid && hazard`): `out_valid <= 0`, control fields <= NOP word, `bubble_cnt++` (saturates at all-ones).
- **Idle** (`adv && !in_valid`): `out_valid <= 0`.
- Load tracking:
  - On accepting an `LW` with `wa != 0`: `pend_wa <= rt`, `pend_cnt <= LOAD_STALL`.
  - Otherwise, on every `adv` cycle with `pend_cnt > 0`: `pend_cnt--`. This applies to bubbles, idles and accepts alike.
- Unused read ports decode to `REG_0`, so they never match `pend_wa`.
- Decode rules:
  - R-type (`ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU`): `wa=rd`, `ra1=rs`, `ra2=rt`, `WREN`, `ALU_SRC_REG`.
  - Fixed shifts (`SLL SRL SRA`): `ra1=rt`, `ra2=REG_0`, `ALU_SRC_SHA`.
  - Variable shifts (`SLLV SRLV SRAV`): `ra1=rt`, `ra2=rs`, `ALU_SRC_REG`.
  - Immediate ALU ops: `wa=rt`, `ra1=rs`, `ALU_SRC_IMM`. `ADDI ADDIU SLTI SLTIU` are sign-extended; `ANDI ORI XORI` are zero-extended.
  - `LW`: `wa=rt`, `ra1=rs`, `MEM_READ`, `REG_SRC_MEM`, `WREN`, sign-extended.
  - `SW`: `ra1=rs`, `ra2=rt`, `MEM_WRITE`, `WDIS`, sign-extended.
  - `BEQ`/`BNE`: `ra1=rs`, `ra2=rt`, `F_SUBU`, `PC_SRC_BRCH`, `WDIS`, sign-extended.
  - `J`: `PC_SRC_JUMP`, `WDIS`, `ra1=ra2=REG_0`.
  - `JAL`: `PC_SRC_JUMP`, `wa=31`, `WREN`, `link=1`.
  - `SYSCALL`: `ra1=REG_V0`, `ra2=REG_A0`, `WDIS`.
  - `BREAK`: NOP.
- Illegal encodings: `illegal=1` plus the NOP word.
- NOP word: `wa=ra1=ra2=REG_0`, `WDIS`, `MEM_NOP`, `PC_SRC_NEXT`, `ALU_SRC_REG`, `REG_SRC_ALU`, `IMM_ZERO_EXT`, `alu_op=F_BREAK`, `link=0`, `illegal=0`.
- `imm` and `addr` are always the raw `FLD_IMM` and `FLD_ADDR` fields.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle with no hazards.
- On reset (`rst == 0` at the clock edge): `out_valid=0`, NOP word, `out_pc=0`, `pend_cnt=0`, `pend_wa=0`, `bubble_cnt=0`.
- `in_ready` reads 0 during reset.
- Reset mid-stall clears the pending load; the next instruction is accepted without a bubble.
- While `out_valid && !out_ready`, all outputs hold stable and `pend_cnt` does not change.
- `in_ready` is combinational from `out_valid`, `out_ready`, `inst` and the pending state.
- An `LW` followed by a dependent `LW` re-arms tracking with the new `wa` only once the second `LW` is accepted.

## Test plan
- **Reset values:** hold `rst=0` for 2 cycles, then release -> `out_valid=0`, `bubble_cnt=0`, `in_ready=1`.
- **Back-to-back ALU ops:** stream `addi $t0,$zero,5` (0x20080005), then `add $t1,$t0,$t0` (0x01084820) with `out_ready=1` -> outputs on consecutive cycles. First: `wa=8`, `alu_op=F_ADD`, `ALU_SRC_IMM`. Second: `wa=9`, `ra1=ra2=8`.
- **Load-use stall:** `lw $t0,0($sp)` (0x8FA80000), then `add $t1,$t0,$t0` with `LOAD_STALL=1` -> one cycle `out_valid=0`, `in_ready=0` during the hazard, then the add issues and `bubble_cnt=1`.
- **No false hazard:**
  - `lw $t0`, then `addi $t2,$zero,1`, then `add $t1,$t0,$t0` -> no bubble and `bubble_cnt=0`.
  - `lw $zero,0($sp)`, then `add $t1,$zero,$zero` -> no bubble.
- **Backpressure:** `out_ready=0` for 3 cycles with `in_valid=1` -> outputs frozen, `in_ready=0`, no instruction lost or duplicated after release.
- **Special decodes:**
  - `JAL 0x0100000` (0x0C100000) -> `wa=31`, `link=1`, `PC_SRC_JUMP`.
  - Opcode 0x3F -> `illegal=1`, `reg_wen=WDIS`, `mem_cmd=MEM_NOP`.
  - `sw $t0,4($sp)` -> `reg_wen=WDIS`, `ra2=8`.
